// File: rtl/ntt_mlkem_masked_add_sub_sched.sv
// Round-robin scheduler for the shared masked add/sub butterfly: LAT-aligned tag pipe + credit-protected result FIFO.
// Optional statistics counters are enabled by defining NTT_MLKEM_ADDSUB_SCHED_STATS_EN.

module ntt_mlkem_masked_add_sub_sched #(
  parameter int WIDTH      = 24,
  parameter int TAG_W      = 8,
  parameter int LAT        = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               zeroize,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_sub,
  input  logic [2*WIDTH-1:0] req0_u,
  input  logic [2*WIDTH-1:0] req0_v,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_sub,
  input  logic [2*WIDTH-1:0] req1_u,
  input  logic [2*WIDTH-1:0] req1_v,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic [2*WIDTH-1:0] bfu_u,
  output logic [2*WIDTH-1:0] bfu_v,
  output logic               bfu_sub,
  input  logic [2*WIDTH-1:0] bfu_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_src,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               busy
`ifdef NTT_MLKEM_ADDSUB_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_issue0,
  output logic [31:0]        stat_issue1,
  output logic [31:0]        stat_stall
`endif
);

  localparam int INF_W = $clog2(LAT + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic [LAT-1:0]     vld_q;
  logic [LAT-1:0]     src_q;
  logic [TAG_W-1:0]   tag_q [LAT];
  logic [INF_W-1:0]   infl_q, infl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [2*WIDTH-1:0] mem_res [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_src;

  logic [31:0]        used;
  logic               credit_ok, can_issue, gnt0, gnt1, issue, retire, push, pop;
  logic [TAG_W-1:0]   issue_tag;

  // Credits count ops in flight plus FIFO occupancy, both registered, so a pop frees its credit a cycle later.
  assign used      = 32'(infl_q) + 32'(cnt_q);
  assign credit_ok = used < 32'(FIFO_DEPTH);
  assign can_issue = (state_q == RUN) && !flush_req && !zeroize && credit_ok;
  assign gnt0      = can_issue && req0_valid && (!req1_valid || !rr_q);
  assign gnt1      = can_issue && req1_valid && (!req0_valid || rr_q);
  assign issue     = gnt0 | gnt1;
  assign rr_d      = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : rr_q);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Operands stay at zero unless issued so idle shares never toggle the masked datapath.
  always_comb begin
    bfu_u     = '0;
    bfu_v     = '0;
    bfu_sub   = 1'b0;
    issue_tag = '0;
    if (gnt0) begin
      bfu_u     = req0_u;
      bfu_v     = req0_v;
      bfu_sub   = req0_sub;
      issue_tag = req0_tag;
    end else if (gnt1) begin
      bfu_u     = req1_u;
      bfu_v     = req1_v;
      bfu_sub   = req1_sub;
      issue_tag = req1_tag;
    end
  end

  assign retire    = vld_q[LAT-1];
  assign push      = retire && !zeroize;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_res   = out_valid ? mem_res[rd_q] : '0;
  assign out_tag   = out_valid ? mem_tag[rd_q] : '0;
  assign out_src   = out_valid ? mem_src[rd_q] : 1'b0;
  assign busy      = (infl_q != '0) || out_valid;

  always_comb begin
    infl_d = infl_q;
    if (issue && !retire)      infl_d = infl_q + INF_W'(1);
    else if (!issue && retire) infl_d = infl_q - INF_W'(1);
    cnt_d = cnt_q;
    if (retire && !pop)        cnt_d = cnt_q + CNT_W'(1);
    else if (!retire && pop)   cnt_d = cnt_q - CNT_W'(1);
  end

  // Drain completes on the cycle whose updates leave both the pipe and the FIFO empty.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (infl_d == '0 && cnt_d == '0) state_d = DONE;
      DONE: begin
        flush_done = !zeroize;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rr_q    <= 1'b0;
      infl_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else if (zeroize) begin
      state_q <= RUN;
      rr_q    <= 1'b0;
      infl_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      src_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else if (zeroize) begin
      vld_q <= '0;
      src_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      src_q[0] <= gnt1;
      tag_q[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        src_q[i] <= src_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_q] <= bfu_res;
      mem_tag[wr_q] <= tag_q[LAT-1];
      mem_src[wr_q] <= src_q[LAT-1];
    end
  end

  a_no_push_on_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (cnt_q == CNT_W'(FIFO_DEPTH))));

`ifdef NTT_MLKEM_ADDSUB_SCHED_STATS_EN
  logic [31:0] stat0_q, stat1_q, stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat0_q <= '0;
      stat1_q <= '0;
      stall_q <= '0;
    end else if (zeroize) begin
      stat0_q <= '0;
      stat1_q <= '0;
      stall_q <= '0;
    end else begin
      if (gnt0 && stat0_q != '1) stat0_q <= stat0_q + 32'd1;
      if (gnt1 && stat1_q != '1) stat1_q <= stat1_q + 32'd1;
      if ((req0_valid || req1_valid) && !issue && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_issue0 = stat0_q;
  assign stat_issue1 = stat1_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_ntt_mlkem_masked_add_sub_sched.sv
// Bench for ntt_mlkem_masked_add_sub_sched: directed tables plus random traffic against an op-queue reference model.
// The bench drives a LAT-deep add/sub-mod-3329 datapath model on bfu_res.

module tb_ntt_mlkem_masked_add_sub_sched;

  localparam int W     = 24;
  localparam int TW    = 8;
  localparam int LAT   = 7;
  localparam int DEPTH = 8;
  localparam int Q     = 3329;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          zeroize;
  logic          r0Valid, r0Sub, r1Valid, r1Sub;
  logic [2*W-1:0] r0U, r0V, r1U, r1V;
  logic [TW-1:0] r0Tag, r1Tag;
  logic          outReady, flushReq;

  logic          req0_ready, req1_ready, bfu_sub, out_valid, out_src, flush_done, busy;
  logic [2*W-1:0] bfu_u, bfu_v, bfu_res, out_res;
  logic [TW-1:0] out_tag;
`ifdef NTT_MLKEM_ADDSUB_SCHED_STATS_EN
  logic [31:0]   stat_issue0, stat_issue1, stat_stall;
`endif

  always #5 clk = ~clk;

  ntt_mlkem_masked_add_sub_sched #(.WIDTH(W), .TAG_W(TW), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .req0_valid(r0Valid), .req0_ready(req0_ready), .req0_sub(r0Sub), .req0_u(r0U), .req0_v(r0V), .req0_tag(r0Tag),
    .req1_valid(r1Valid), .req1_ready(req1_ready), .req1_sub(r1Sub), .req1_u(r1U), .req1_v(r1V), .req1_tag(r1Tag),
    .bfu_u(bfu_u), .bfu_v(bfu_v), .bfu_sub(bfu_sub), .bfu_res(bfu_res),
    .out_valid(out_valid), .out_ready(outReady), .out_res(out_res), .out_tag(out_tag), .out_src(out_src),
    .flush_req(flushReq), .flush_done(flush_done), .busy(busy)
`ifdef NTT_MLKEM_ADDSUB_SCHED_STATS_EN
    , .stat_issue0(stat_issue0), .stat_issue1(stat_issue1), .stat_stall(stat_stall)
`endif
  );

  function automatic logic [2*W-1:0] bfuOp(logic [2*W-1:0] u, logic [2*W-1:0] v, logic sub);
    int a0, a1, b0, b1, r0, r1;
    a0 = int'(u[W-1:0]);  a1 = int'(u[2*W-1:W]);
    b0 = int'(v[W-1:0]);  b1 = int'(v[2*W-1:W]);
    r0 = sub ? (((a0 - b0) % Q) + Q) % Q : (a0 + b0) % Q;
    r1 = sub ? (((a1 - b1) % Q) + Q) % Q : (a1 + b1) % Q;
    return {W'(r1), W'(r0)};
  endfunction

  logic [2*W-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= bfuOp(bfu_u, bfu_v, bfu_sub);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bfu_res = pipe[LAT-1];

  typedef struct {
    logic [2*W-1:0] res;
    logic [TW-1:0]  tag;
    logic           src;
    int             readyAt;
  } op_t;

  // Reference: every accepted op waits in issue order and becomes visible LAT+1 cycles after its issue cycle.
  op_t  sb[$];
  int   mState;
  logic mLast;
  int   cyc;
  int   nVec, nMis;
  int   mStat0, mStat1, mStall;

  logic sRdy0, sRdy1, sBfuSub, sOutValid, sOutSrc, sFlushDone, sBusy;
  logic [2*W-1:0] sOutRes;
  logic [TW-1:0]  sOutTag;

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus();
    logic canIssue, eg0, eg1, eOv;
    logic [2*W-1:0] eU, eV;
    logic eSub;
    op_t op;
    @(negedge clk);
    canIssue = (mState == 0) && !flushReq && !zeroize && (sb.size() < DEPTH);
    eg0 = canIssue && r0Valid && (!r1Valid || mLast);
    eg1 = canIssue && r1Valid && (!r0Valid || !mLast);
    eOv = (sb.size() > 0) && (sb[0].readyAt <= cyc);
    sRdy0 = req0_ready; sRdy1 = req1_ready; sBfuSub = bfu_sub;
    sOutValid = out_valid; sOutRes = out_res; sOutTag = out_tag; sOutSrc = out_src;
    sFlushDone = flush_done; sBusy = busy;
    eU   = eg0 ? r0U : (eg1 ? r1U : '0);
    eV   = eg0 ? r0V : (eg1 ? r1V : '0);
    eSub = eg0 ? r0Sub : (eg1 ? r1Sub : 1'b0);
    checkOutput("req0_ready", 64'(sRdy0), 64'(eg0));
    checkOutput("req1_ready", 64'(sRdy1), 64'(eg1));
    checkOutput("bfu_u", 64'(bfu_u), 64'(eU));
    checkOutput("bfu_v", 64'(bfu_v), 64'(eV));
    checkOutput("bfu_sub", 64'(sBfuSub), 64'(eSub));
    checkOutput("out_valid", 64'(sOutValid), 64'(eOv));
    if (eOv) begin
      checkOutput("out_res", 64'(sOutRes), 64'(sb[0].res));
      checkOutput("out_tag", 64'(sOutTag), 64'(sb[0].tag));
      checkOutput("out_src", 64'(sOutSrc), 64'(sb[0].src));
    end
    checkOutput("busy", 64'(sBusy), 64'(sb.size() != 0));
    checkOutput("flush_done", 64'(sFlushDone), 64'((mState == 2) && !zeroize));
`ifdef NTT_MLKEM_ADDSUB_SCHED_STATS_EN
    checkOutput("stat_issue0", 64'(stat_issue0), 64'(mStat0));
    checkOutput("stat_issue1", 64'(stat_issue1), 64'(mStat1));
    checkOutput("stat_stall", 64'(stat_stall), 64'(mStall));
`endif
    @(posedge clk);
    #1;
    if (zeroize) begin
      sb.delete();
      mState = 0; mLast = 1'b1;
      mStat0 = 0; mStat1 = 0; mStall = 0;
    end else begin
      if (eOv && outReady) void'(sb.pop_front());
      if (eg0 || eg1) begin
        op.res     = eg0 ? bfuOp(r0U, r0V, r0Sub) : bfuOp(r1U, r1V, r1Sub);
        op.tag     = eg0 ? r0Tag : r1Tag;
        op.src     = eg1;
        op.readyAt = cyc + LAT + 1;
        sb.push_back(op);
        mLast = eg1;
      end
      if (eg0) mStat0++;
      if (eg1) mStat1++;
      if ((r0Valid || r1Valid) && !(eg0 || eg1)) mStall++;
      case (mState)
        0: if (flushReq) mState = 1;
        1: if (sb.size() == 0) mState = 2;
        default: mState = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic randData();
    r0U = {W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1))};
    r0V = {W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1))};
    r1U = {W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1))};
    r1V = {W'($urandom_range(0, Q-1)), W'($urandom_range(0, Q-1))};
    r0Sub = 1'($urandom_range(0, 1)); r1Sub = 1'($urandom_range(0, 1));
    r0Tag = TW'($urandom);            r1Tag = TW'($urandom);
  endtask

  task automatic idle(input int n);
    r0Valid = 1'b0; r1Valid = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  typedef struct {
    logic          src;
    logic          sub;
    int            u0;
    int            v0;
    logic [TW-1:0] tag;
    int            expSum;
  } single_t;

  task automatic runSingle(input single_t s);
    int issueCyc, c, lat, sum;
    logic got;
    outReady = 1'b1;
    if (s.src) begin
      r1Valid = 1'b1; r1Sub = s.sub; r1U = {W'(0), W'(s.u0)}; r1V = {W'(0), W'(s.v0)}; r1Tag = s.tag;
    end else begin
      r0Valid = 1'b1; r0Sub = s.sub; r0U = {W'(0), W'(s.u0)}; r0V = {W'(0), W'(s.v0)}; r0Tag = s.tag;
    end
    issueCyc = cyc;
    applyStimulus();
    checkOutput("single_ready", 64'(s.src ? sRdy1 : sRdy0), 64'(1));
    checkOutput("single_bfu_sub_issue", 64'(sBfuSub), 64'(s.sub));
    r0Valid = 1'b0; r1Valid = 1'b0;
    got = 1'b0; lat = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      c = cyc;
      applyStimulus();
      if (n == 0) checkOutput("single_bfu_sub_idle", 64'(sBfuSub), 64'(0));
      if (sOutValid) begin
        got = 1'b1;
        lat = c - issueCyc - 1;
        sum = (int'(sOutRes[W-1:0]) + int'(sOutRes[2*W-1:W])) % Q;
        checkOutput("single_sum", 64'(sum), 64'(s.expSum));
        checkOutput("single_tag", 64'(sOutTag), 64'(s.tag));
        checkOutput("single_src", 64'(sOutSrc), 64'(s.src));
      end
    end
    checkOutput("single_latency", 64'(lat), 64'(LAT));
  endtask

  typedef struct {
    logic v0;
    logic v1;
    logic e0;
    logic e1;
  } arb_t;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    single_t singles [4];
    arb_t    arb [6];
    int      grants, pulses, lastPop, doneCyc, c;
    logic    doneSeen;
    logic    srcSeen [$];

    singles[0] = '{src: 1'b0, sub: 1'b0, u0: 100,  v0: 200, tag: 8'h12, expSum: 300};
    singles[1] = '{src: 1'b0, sub: 1'b1, u0: 5,    v0: 10,  tag: 8'h34, expSum: 3324};
    singles[2] = '{src: 1'b1, sub: 1'b0, u0: 3000, v0: 500, tag: 8'h56, expSum: 171};
    singles[3] = '{src: 1'b1, sub: 1'b1, u0: 7,    v0: 7,   tag: 8'hA5, expSum: 0};
    for (int i = 0; i < 6; i++) arb[i] = '{v0: 1'b1, v1: 1'b1, e0: (i % 2 == 0), e1: (i % 2 == 1)};

    nVec = 0; nMis = 0; cyc = 0;
    mState = 0; mLast = 1'b1; mStat0 = 0; mStat1 = 0; mStall = 0;
    reset_n = 1'b0; zeroize = 1'b0; flushReq = 1'b0; outReady = 1'b0;
    r0Valid = 1'b0; r1Valid = 1'b0;
    randData();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_flush_done", 64'(flush_done), 64'(0));
    checkOutput("reset_bfu_u", 64'(bfu_u), 64'(0));
    checkOutput("reset_out_res", 64'(out_res), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single operations");
    for (int i = 0; i < 4; i++) runSingle(singles[i]);

    $display("[TB] contention");
    zeroize = 1'b1; applyStimulus(); zeroize = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      randData();
      r0Valid = arb[i].v0; r1Valid = arb[i].v1;
      applyStimulus();
      checkOutput("arb_ready0", 64'(sRdy0), 64'(arb[i].e0));
      checkOutput("arb_ready1", 64'(sRdy1), 64'(arb[i].e1));
    end
    r0Valid = 1'b0; r1Valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus();
      if (sOutValid) srcSeen.push_back(sOutSrc);
    end
    checkOutput("arb_fifo_count", 64'(srcSeen.size()), 64'(6));
    for (int i = 0; i < srcSeen.size() && i < 6; i++)
      checkOutput("arb_fifo_order", 64'(srcSeen[i]), 64'(arb[i].e1));

    $display("[TB] backpressure");
    outReady = 1'b0; r0Valid = 1'b1; grants = 0;
    for (int i = 0; i < 12; i++) begin
      randData();
      applyStimulus();
      grants += int'(sRdy0);
    end
    checkOutput("bp_grants", 64'(grants), 64'(DEPTH));
    checkOutput("bp_ready_low", 64'(sRdy0), 64'(0));
    outReady = 1'b1; applyStimulus();
    checkOutput("bp_pop_cycle_ready", 64'(sRdy0), 64'(0));
    checkOutput("bp_pop_cycle_valid", 64'(sOutValid), 64'(1));
    outReady = 1'b0; applyStimulus();
    checkOutput("bp_regrant", 64'(sRdy0), 64'(1));
    applyStimulus();
    checkOutput("bp_full_again", 64'(sRdy0), 64'(0));
    outReady = 1'b1;
    idle(20);

    $display("[TB] flush");
    r0Valid = 1'b1;
    repeat (3) begin randData(); applyStimulus(); end
    r0Valid = 1'b0; r1Valid = 1'b1; flushReq = 1'b1;
    applyStimulus();
    checkOutput("flush_req_cycle_ready1", 64'(sRdy1), 64'(0));
    flushReq = 1'b0;
    doneSeen = 1'b0; pulses = 0; lastPop = -1; doneCyc = -1;
    for (int n = 0; n < 30; n++) begin
      c = cyc;
      applyStimulus();
      if (!doneSeen) begin
        if (sOutValid) lastPop = c;
        if (!sFlushDone) checkOutput("flush_hold_ready1", 64'(sRdy1), 64'(0));
      end
      if (sFlushDone) begin
        pulses++;
        if (!doneSeen) doneCyc = c;
        doneSeen = 1'b1;
      end
    end
    checkOutput("flush_done_pulses", 64'(pulses), 64'(1));
    checkOutput("flush_done_timing", 64'(doneCyc), 64'(lastPop + 1));
    idle(15);

    $display("[TB] zeroize");
    outReady = 1'b0; r0Valid = 1'b1;
    repeat (4) begin randData(); applyStimulus(); end
    idle(2);
    zeroize = 1'b1; applyStimulus(); zeroize = 1'b0;
    applyStimulus();
    checkOutput("zeroize_busy", 64'(sBusy), 64'(0));
    checkOutput("zeroize_out_valid", 64'(sOutValid), 64'(0));
    for (int n = 0; n < 10; n++) begin
      applyStimulus();
      checkOutput("zeroize_quiet", 64'(sOutValid), 64'(0));
    end
    runSingle(singles[0]);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      randData();
      r0Valid  = ($urandom_range(0, 2) != 0);
      r1Valid  = ($urandom_range(0, 2) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      flushReq = ($urandom_range(0, 39) == 0);
      zeroize  = ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    flushReq = 1'b0; zeroize = 1'b0; outReady = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
